fft_peak_finder: RTL and testbench
==================================

Name: fft_peak_finder

Overview:
- Consumes the per-bin magnitude-squared stream produced after the FFT (mag_sq/mag_valid, plus a start-of-frame marker).
- Over each N_BINS-bin frame, finds the largest bin within a configurable search window and reports its magnitude and index.
- The result is held for a downstream ready/valid consumer (tone detector / CSR capture), with overrun and framing-error reporting.

Parameters:
- W, 16: FFT sample width; input magnitude is 2W+1 bits unsigned.
- N_BINS, 1024: bins per frame, power of two, >= 4.
- MIN_BIN, 1: lowest bin searched, inclusive (1 excludes DC).
- MAX_BIN, 511: highest bin searched, inclusive; requires MIN_BIN <= MAX_BIN <= N_BINS-1.
- IDX_W, $clog2(N_BINS): bin index width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mag_valid  in  1  mag_sq valid this cycle; no backpressure, every valid sample is consumed.
- mag_sop  in  1  qualifies the current valid sample as bin 0; ignored when mag_valid=0.
- mag_sq  in  2W+1  unsigned magnitude squared.
- threshold  in  2W+1  detection threshold, sampled at frame end.
- peak_valid  out  1  result available.
- peak_ready  in  1  consumer accepts the result when peak_valid & peak_ready.
- peak_mag  out  2W+1  peak magnitude.
- peak_bin  out  IDX_W  peak bin index.
- peak_above  out  1  peak_mag >= threshold, evaluated at frame end.
- frame_err  out  1  one-cycle pulse: frame aborted by an early sop.
- overrun  out  1  sticky: an unaccepted result was overwritten.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, bin_cnt=0, best registers 0, FSM=SYNC. Reset mid-frame discards the frame and any held result.
- FSM SYNC: ignores samples until mag_valid & mag_sop. That sample is bin 0 and the FSM moves to ACCUM with bin_cnt=1.
- FSM ACCUM: on each mag_valid, the sample's bin is bin_cnt, then bin_cnt increments. Cycles with mag_valid low (gaps) change nothing.
- Search window, bins MIN_BIN..MAX_BIN:
  - At bin==MIN_BIN, load best_mag=mag_sq and best_bin=MIN_BIN unconditionally.
  - At later in-window bins, update only if mag_sq > best_mag (strict). On ties the lower bin wins.
  - Out-of-window bins are ignored.
  - Comparison is unsigned, full 2W+1 bits, no truncation.
- Frame end: the valid sample with bin==N_BINS-1. On the next clk edge:
  - peak_mag <= best_mag, peak_bin <= best_bin, peak_above <= (best_mag >= threshold), peak_valid <= 1.
  - Latency: peak_valid rises exactly 1 cycle after the last-bin sample is presented.
  - bin_cnt wraps to 0 and the FSM stays in ACCUM. The next valid sample is bin 0 with or without sop.
- sop handling in ACCUM:
  - sop with bin_cnt==0: normal frame start.
  - sop with bin_cnt!=0: the current frame is aborted. frame_err pulses for 1 cycle, no result is produced, and the sop sample is taken as bin 0 (bin_cnt=1).
- Output handshake:
  - peak_valid & peak_ready: the result is consumed and peak_valid drops next cycle, unless a new result is loaded on that same edge, in which case peak_valid stays 1 with the new data and no overrun is flagged.
  - A new result arriving while peak_valid=1 & !peak_ready: the result is overwritten with the new one and overrun <= 1.
- overrun: sticky. Cleared by ovr_clr or reset. If ovr_clr and a new overrun occur in the same cycle, set wins.
- Outputs are registered. peak_mag, peak_bin and peak_above stay stable while peak_valid=1 & !peak_ready, except on overwrite.
- If MIN_BIN==MAX_BIN, the peak is always that bin.

Test Plan (bench overrides N_BINS=16, MIN_BIN=1, MAX_BIN=7, W=16):
- Frame with sop on bin 0, mag = 10*bin, bin5 = 1000, threshold 900, peak_ready=1 -> peak_valid pulses 1 cycle, 1 cycle after the bin-15 sample, with peak_mag=1000, peak_bin=5, peak_above=1. Repeat with threshold 1001 -> peak_above=0.
- Bins 3 and 6 = 500, bin0 = 99999, bin10 = 2000, all other bins 1 -> peak_bin=3, peak_mag=500 (tie keeps lower bin; DC and out-of-window bins excluded).
- Same frame as the first scenario with random 0-3 cycle gaps in mag_valid, plus back-to-back second frame without sop -> identical results for both frames.
- sop asserted again at bin 9 -> frame_err=1 for one cycle, no peak_valid. Result appears 1 cycle after the 16th sample counted from the new sop.
- peak_ready=0 across two frames (peaks 1000 at bin5, then 700 at bin2) -> after frame 2, peak_mag=700, peak_bin=2, overrun=1. ovr_clr pulse -> overrun=0; peak_ready=1 -> peak_valid drops next cycle.
- Assert reset_n=0 mid-frame at bin 8 -> all outputs 0 immediately. After release, samples without sop produce no result until the first sop.

Source files
------------

// File: rtl/fft_peak_finder.sv
`default_nettype none
// ============================================================================
// Module   : fft_peak_finder
// Purpose  : Per-frame peak search over post-FFT magnitude-squared bins.
//            Result is held on a ready/valid port, with overrun/framing flags.
// Revision : 1.0
// ============================================================================
module fft_peak_finder #(
    parameter int W       = 16,
    parameter int N_BINS  = 1024,
    parameter int MIN_BIN = 1,
    parameter int MAX_BIN = 511,
    parameter int IDX_W   = $clog2(N_BINS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mag_valid,
    input  logic             mag_sop,
    input  logic [2*W:0]     mag_sq,
    input  logic [2*W:0]     threshold,
    output logic             peak_valid,
    input  logic             peak_ready,
    output logic [2*W:0]     peak_mag,
    output logic [IDX_W-1:0] peak_bin,
    output logic             peak_above,
    output logic             frame_err,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int MAG_W = 2*W + 1;

    localparam logic [0:0] S_SYNC  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    // Window bounds carry one extra bit so neither comparison degenerates
    // to a constant when MIN_BIN=0 or MAX_BIN=N_BINS-1.
    localparam logic [IDX_W:0]   c_min_bin  = (IDX_W+1)'(MIN_BIN);
    localparam logic [IDX_W:0]   c_max_bin  = (IDX_W+1)'(MAX_BIN);
    localparam logic [IDX_W-1:0] c_last_bin = IDX_W'(N_BINS - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] r_bin_cnt;
    logic [MAG_W-1:0] r_best_mag;
    logic [IDX_W-1:0] r_best_bin;
    logic             r_peak_valid;
    logic [MAG_W-1:0] r_peak_mag;
    logic [IDX_W-1:0] r_peak_bin;
    logic             r_peak_above;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_take;
    logic             w_abort;
    logic [IDX_W-1:0] w_bin;
    logic [IDX_W:0]   w_bin_ext;
    logic             w_load_min;
    logic             w_upd;
    logic             w_frame_end;
    logic [MAG_W-1:0] w_best_mag_nxt;
    logic [IDX_W-1:0] w_best_bin_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A sop always redefines the current sample as bin 0; in ACCUM it aborts
    // the frame unless the counter had already wrapped.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_abort     = 1'b0;
        w_bin       = r_bin_cnt;
        case (r_state)
            S_SYNC: begin
                if (mag_valid && mag_sop) begin
                    w_take      = 1'b1;
                    w_bin       = '0;
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (mag_valid) begin
                    w_take = 1'b1;
                    if (mag_sop) begin
                        w_bin   = '0;
                        w_abort = (r_bin_cnt != '0);
                    end
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase
    end

    assign w_bin_ext   = {1'b0, w_bin};
    assign w_load_min  = w_take && (w_bin_ext == c_min_bin);
    assign w_upd       = w_take && (w_bin_ext > c_min_bin) && (w_bin_ext <= c_max_bin)
                         && (mag_sq > r_best_mag);
    assign w_frame_end = w_take && (w_bin == c_last_bin);

    // The last bin may itself be in the window, so the result is taken from
    // the post-update best values rather than the registers.
    always_comb begin
        w_best_mag_nxt = r_best_mag;
        w_best_bin_nxt = r_best_bin;
        if (w_load_min || w_upd) begin
            w_best_mag_nxt = mag_sq;
            w_best_bin_nxt = w_bin;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bin_cnt  <= '0;
            r_best_mag <= '0;
            r_best_bin <= '0;
        end else begin
            if (w_take) begin
                r_bin_cnt <= w_bin + IDX_W'(1);
            end
            r_best_mag <= w_best_mag_nxt;
            r_best_bin <= w_best_bin_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_peak_valid <= 1'b0;
            r_peak_mag   <= '0;
            r_peak_bin   <= '0;
            r_peak_above <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_abort;
            if (w_frame_end) begin
                r_peak_valid <= 1'b1;
                r_peak_mag   <= w_best_mag_nxt;
                r_peak_bin   <= w_best_bin_nxt;
                r_peak_above <= (w_best_mag_nxt >= threshold);
            end else if (r_peak_valid && peak_ready) begin
                r_peak_valid <= 1'b0;
            end
            if (w_frame_end && r_peak_valid && !peak_ready) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign peak_valid = r_peak_valid;
    assign peak_mag   = r_peak_mag;
    assign peak_bin   = r_peak_bin;
    assign peak_above = r_peak_above;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_peak_finder
// Purpose  : Self-checking bench for fft_peak_finder against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_fft_peak_finder;

    localparam int W    = 16;
    localparam int N    = 16;
    localparam int MINB = 1;
    localparam int MAXB = 7;
    localparam int IW   = 4;
    localparam int MW   = 2*W + 1;

    typedef logic [MW-1:0] frame_t [N];

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mag_valid;
    logic          mag_sop;
    logic [MW-1:0] mag_sq;
    logic [MW-1:0] threshold;
    logic          peak_valid;
    logic          peak_ready;
    logic [MW-1:0] peak_mag;
    logic [IW-1:0] peak_bin;
    logic          peak_above;
    logic          frame_err;
    logic          overrun;
    logic          ovr_clr;

    always #5 clk = ~clk;

    fft_peak_finder #(
        .W(W), .N_BINS(N), .MIN_BIN(MINB), .MAX_BIN(MAXB), .IDX_W(IW)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .mag_valid(mag_valid), .mag_sop(mag_sop),
        .mag_sq(mag_sq), .threshold(threshold), .peak_valid(peak_valid),
        .peak_ready(peak_ready), .peak_mag(peak_mag), .peak_bin(peak_bin),
        .peak_above(peak_above), .frame_err(frame_err), .overrun(overrun),
        .ovr_clr(ovr_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level reference: collect a whole frame, search it at frame end.
    bit            m_synced;
    int            m_cnt;
    logic [MW-1:0] m_frame [N];
    bit            m_pv, m_pabove, m_ferr, m_ovr;
    logic [MW-1:0] m_pmag;
    int            m_pbin;

    task automatic model_reset();
        m_synced = 0; m_cnt = 0;
        m_pv = 0; m_pabove = 0; m_ferr = 0; m_ovr = 0;
        m_pmag = '0; m_pbin = 0;
    endtask

    task automatic check_outputs();
        check("peak_valid", peak_valid, m_pv);
        check("frame_err", frame_err, m_ferr);
        check("overrun", overrun, m_ovr);
        if (m_pv) begin
            check("peak_mag", peak_mag, m_pmag);
            check("peak_bin", peak_bin, m_pbin);
            check("peak_above", peak_above, m_pabove);
        end
    endtask

    task automatic cycle(input bit v, input bit s, input logic [MW-1:0] m);
        bit load;
        bit ferr;
        int bi;
        load = 0; ferr = 0; bi = MINB;
        mag_valid = v; mag_sop = s; mag_sq = m;
        if (v) begin
            if (s) begin
                if (m_synced && m_cnt != 0) ferr = 1;
                m_synced = 1;
                m_cnt    = 0;
            end
            if (m_synced) begin
                m_frame[m_cnt] = m;
                if (m_cnt == N-1) begin
                    load = 1;
                    for (int b = MINB + 1; b <= MAXB; b++)
                        if (m_frame[b] > m_frame[bi]) bi = b;
                end
                m_cnt = (m_cnt + 1) % N;
            end
        end
        if (load && m_pv && !peak_ready) m_ovr = 1;
        else if (ovr_clr)                m_ovr = 0;
        if (load) begin
            m_pv = 1; m_pmag = m_frame[bi]; m_pbin = bi;
            m_pabove = (m_frame[bi] >= threshold);
        end else if (m_pv && peak_ready) begin
            m_pv = 0;
        end
        m_ferr = ferr;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, MW'($urandom));
    endtask

    task automatic send_frame(input frame_t f, input bit sop, input int maxgap);
        for (int b = 0; b < N; b++) begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            cycle(1'b1, sop && (b == 0), f[b]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pv"},    peak_valid, 0);
        check({tag, "_mag"},   peak_mag,   0);
        check({tag, "_bin"},   peak_bin,   0);
        check({tag, "_above"}, peak_above, 0);
        check({tag, "_ferr"},  frame_err,  0);
        check({tag, "_ovr"},   overrun,    0);
    endtask

    frame_t f1, f2, f3;

    initial begin
        reset_n = 0; mag_valid = 0; mag_sop = 0; mag_sq = '0;
        threshold = '0; peak_ready = 1; ovr_clr = 0;
        model_reset();
        for (int b = 0; b < N; b++) begin
            f1[b] = MW'(10 * b);
            f2[b] = MW'(1);
            f3[b] = MW'(10);
        end
        f1[5] = MW'(1000);
        f2[3] = MW'(500); f2[6] = MW'(500); f2[0] = MW'(99999); f2[10] = MW'(2000);
        f3[2] = MW'(700);

        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1;

        // Basic frame, above threshold, then below
        threshold = MW'(900);
        idle(2);
        send_frame(f1, 1, 0);
        check("s1_pv", peak_valid, 1);
        check("s1_mag", peak_mag, 1000);
        check("s1_bin", peak_bin, 5);
        check("s1_above", peak_above, 1);
        idle(1);
        check("s1_pulse", peak_valid, 0);
        threshold = MW'(1001);
        send_frame(f1, 1, 0);
        check("s2_above", peak_above, 0);
        idle(1);

        // Tie goes to lower bin; DC and out-of-window excluded
        send_frame(f2, 1, 0);
        check("s3_bin", peak_bin, 3);
        check("s3_mag", peak_mag, 500);
        idle(1);

        // Gapped frame followed by back-to-back frame without sop
        threshold = MW'(900);
        send_frame(f1, 1, 3);
        check("s4a_mag", peak_mag, 1000);
        check("s4a_bin", peak_bin, 5);
        send_frame(f1, 0, 3);
        check("s4b_pv", peak_valid, 1);
        check("s4b_mag", peak_mag, 1000);
        check("s4b_bin", peak_bin, 5);
        idle(1);

        // Early sop at bin 9 aborts the frame
        for (int b = 0; b < 9; b++) cycle(1'b1, b == 0, f1[b]);
        cycle(1'b1, 1'b1, f1[0]);
        check("s5_ferr", frame_err, 1);
        check("s5_nopv", peak_valid, 0);
        for (int b = 1; b < N; b++) cycle(1'b1, 1'b0, f1[b]);
        check("s5_pv", peak_valid, 1);
        check("s5_bin", peak_bin, 5);
        idle(1);

        // Overrun with consumer stalled
        peak_ready = 0;
        send_frame(f1, 1, 0);
        check("s6a_mag", peak_mag, 1000);
        check("s6a_ovr", overrun, 0);
        idle(2);
        send_frame(f3, 0, 0);
        check("s6b_mag", peak_mag, 700);
        check("s6b_bin", peak_bin, 2);
        check("s6b_ovr", overrun, 1);
        ovr_clr = 1;
        idle(1);
        ovr_clr = 0;
        check("s6_clr", overrun, 0);
        peak_ready = 1;
        idle(1);
        check("s6_drop", peak_valid, 0);

        // Reset mid-frame with a held result and overrun pending
        peak_ready = 0;
        send_frame(f1, 1, 0);
        send_frame(f1, 0, 0);
        for (int b = 0; b < 9; b++) cycle(1'b1, 1'b0, f1[b]);
        reset_n = 0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk); #1;
        reset_n = 1;
        peak_ready = 1;
        for (int i = 0; i < 2*N; i++) cycle(1'b1, 1'b0, f1[i % N]);
        check("s7_nosync", peak_valid, 0);
        send_frame(f1, 1, 0);
        check("s7_pv", peak_valid, 1);
        check("s7_mag", peak_mag, 1000);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            peak_ready = ($urandom % 2) == 0;
            ovr_clr    = ($urandom % 16) == 0;
            threshold  = ($urandom % 2) ? {1'($urandom), 32'($urandom)} : MW'($urandom % 8);
            cycle(($urandom % 4) != 0, ($urandom % 24) == 0,
                  ($urandom % 2) ? {1'($urandom), 32'($urandom)} : MW'($urandom % 8));
        end
        peak_ready = 1; ovr_clr = 0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
